tlb_entry_array: RTL and testbench

Parametrised, fully associative TLB entry store for the MIPS32 MMU; the successor to the fixed 8x24 TLB RAM. Holds DEPTH entries of {valid, tag, data}, adds a combinational associative lookup with hit, index and multi-hit reporting, plus indexed and random (round-robin) writes. Also supports whole-array invalidate and an indexed read port for TLB-read style instructions. Sits between the address-translation path (lookup port) and the CP0 TLB instruction logic (write, read and invalidate ports).

---
 rtl/tlb_entry_array.sv | 160 ++++++++++++++++
 tb/tb_tlb_entry_array.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tlb_entry_array.sv
// -----------------------------------------------------------------------------
// tlb_entry_array
//
// Fully associative TLB entry store. Each of DEPTH entries holds {valid, tag,
// data}. A combinational lookup port reports hit, lowest matching index,
// payload and multi-hit. A combinational read port returns one entry by index.
// Writes go to an explicit index or to the round-robin replacement pointer.
// Whole-array invalidation is also supported.
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   rst       in   synchronous active-high reset (clears valids and rnd_ptr)
//   lk_tag    in   lookup tag
//   lk_hit    out  some valid entry matches lk_tag
//   lk_index  out  lowest matching index (0 on miss)
//   lk_data   out  payload of lk_index (0 on miss)
//   lk_multi  out  two or more valid entries match lk_tag
//   wr_en     in   write request
//   wr_mode   in   0 = indexed write to wr_index, 1 = random write to rnd_ptr
//   wr_index  in   target of an indexed write
//   wr_tag    in   tag to write
//   wr_data   in   payload to write
//   inv_all   in   clear every valid bit (drops a concurrent write)
//   rd_index  in   read-port index
//   rd_valid  out  valid bit at rd_index
//   rd_tag    out  tag at rd_index (0 if invalid or out of range)
//   rd_data   out  payload at rd_index (0 if invalid or out of range)
//   rnd_ptr   out  current replacement pointer
// -----------------------------------------------------------------------------
module tlb_entry_array #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_hit,
  output logic [IDX_W-1:0]  lk_index,
  output logic [DATA_W-1:0] lk_data,
  output logic              lk_multi,
  input  logic              wr_en,
  input  logic              wr_mode,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inv_all,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rnd_ptr
);

  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  rnd_ptr_q, rnd_ptr_d;

  logic [IDX_W-1:0]  wr_tgt;
  logic              wr_accept;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  match;

  // ---------------------------------------------------------------------------
  // Write decode and next state
  // ---------------------------------------------------------------------------
  assign wr_tgt    = wr_mode ? rnd_ptr_q : wr_index;
  // Reset and invalidate both take precedence over a write on the same edge.
  assign wr_accept = wr_en && !inv_all && !rst;

  // An out-of-range indexed target matches no entry, so the write is dropped
  // without any explicit range check. rnd_ptr is always in range.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_accept && (wr_tgt == IDX_W'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d   = inv_all ? '0 : (valid_q | wr_sel);
    rnd_ptr_d = rnd_ptr_q;
    if (wr_accept && wr_mode) begin
      rnd_ptr_d = (rnd_ptr_q == PTR_LAST) ? '0 : rnd_ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      rnd_ptr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rnd_ptr_q <= rnd_ptr_d;
    end
  end

  // Tag and payload storage is not reset; every output is masked by valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_sel[i]) begin
        tag_q[i]  <= wr_tag;
        data_q[i] <= wr_data;
      end
    end
  end

  assign rnd_ptr = rnd_ptr_q;

  // ---------------------------------------------------------------------------
  // Associative lookup
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      match[i] = valid_q[i] && (tag_q[i] == lk_tag);
    end
  end

  // Scan upward: the first match wins the index, any later one flags multi.
  always_comb begin
    lk_hit   = 1'b0;
    lk_multi = 1'b0;
    lk_index = '0;
    lk_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (match[i]) begin
        if (lk_hit) begin
          lk_multi = 1'b1;
        end else begin
          lk_hit   = 1'b1;
          lk_index = IDX_W'(i);
          lk_data  = data_q[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Indexed read port; indices at or beyond DEPTH select nothing and read 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_valid = 1'b0;
    rd_tag   = '0;
    rd_data  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((rd_index == IDX_W'(i)) && valid_q[i]) begin
        rd_valid = 1'b1;
        rd_tag   = tag_q[i];
        rd_data  = data_q[i];
      end
    end
  end

endmodule

// File: tb/tb_tlb_entry_array.sv
module tb_tlb_entry_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: DEPTH 8
  logic        rst, lk_hit, lk_multi, wr_en, wr_mode, inv_all, rd_valid;
  logic [19:0] lk_tag, wr_tag, rd_tag;
  logic [23:0] lk_data, wr_data, rd_data;
  logic [2:0]  lk_index, wr_index, rd_index, rnd_ptr;

  // DUT B: DEPTH 6 with a 3-bit index
  logic        b_rst, b_lk_hit, b_lk_multi, b_wr_en, b_wr_mode, b_inv_all, b_rd_valid;
  logic [19:0] b_lk_tag, b_wr_tag, b_rd_tag;
  logic [23:0] b_lk_data, b_wr_data, b_rd_data;
  logic [2:0]  b_lk_index, b_wr_index, b_rd_index, b_rnd_ptr;

  tlb_entry_array #(.DEPTH(8), .IDX_W(3), .TAG_W(20), .DATA_W(24)) u_a (
    .clk(clk), .rst(rst), .lk_tag(lk_tag), .lk_hit(lk_hit), .lk_index(lk_index),
    .lk_data(lk_data), .lk_multi(lk_multi), .wr_en(wr_en), .wr_mode(wr_mode),
    .wr_index(wr_index), .wr_tag(wr_tag), .wr_data(wr_data), .inv_all(inv_all),
    .rd_index(rd_index), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_data(rd_data),
    .rnd_ptr(rnd_ptr));

  tlb_entry_array #(.DEPTH(6), .IDX_W(3), .TAG_W(20), .DATA_W(24)) u_b (
    .clk(clk), .rst(b_rst), .lk_tag(b_lk_tag), .lk_hit(b_lk_hit), .lk_index(b_lk_index),
    .lk_data(b_lk_data), .lk_multi(b_lk_multi), .wr_en(b_wr_en), .wr_mode(b_wr_mode),
    .wr_index(b_wr_index), .wr_tag(b_wr_tag), .wr_data(b_wr_data), .inv_all(b_inv_all),
    .rd_index(b_rd_index), .rd_valid(b_rd_valid), .rd_tag(b_rd_tag), .rd_data(b_rd_data),
    .rnd_ptr(b_rnd_ptr));

  typedef struct {
    logic        rst, we, wm;
    logic [2:0]  wi;
    logic [19:0] wt;
    logic [23:0] wd;
    logic        inv;
    logic [19:0] lt;
    logic [2:0]  ri;
    logic        e_hit;
    logic [2:0]  e_idx;
    logic [23:0] e_data;
    logic        e_multi, e_rv;
    logic [19:0] e_rt;
    logic [23:0] e_rd;
    logic [2:0]  e_ptr;
  } vec_t;

  vec_t vq[$];

  function automatic void addv(logic r, logic we, logic wm, logic [2:0] wi,
                               logic [19:0] wt, logic [23:0] wd, logic inv,
                               logic [19:0] lt, logic [2:0] ri,
                               logic eh, logic [2:0] ei, logic [23:0] ed, logic em,
                               logic erv, logic [19:0] ert, logic [23:0] erd,
                               logic [2:0] ep);
    vec_t v;
    v.rst = r; v.we = we; v.wm = wm; v.wi = wi; v.wt = wt; v.wd = wd; v.inv = inv;
    v.lt = lt; v.ri = ri; v.e_hit = eh; v.e_idx = ei; v.e_data = ed; v.e_multi = em;
    v.e_rv = erv; v.e_rt = ert; v.e_rd = erd; v.e_ptr = ep;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_mode = 0; wr_index = 0; wr_tag = 0; wr_data = 0;
    inv_all = 0; lk_tag = 0; rd_index = 0;
    b_rst = 1'b1; b_wr_en = 0; b_wr_mode = 0; b_wr_index = 0; b_wr_tag = 0;
    b_wr_data = 0; b_inv_all = 0; b_lk_tag = 0; b_rd_index = 0;

    // Each vector: inputs applied, outputs checked (pre-edge state), then edge.
    //   rst we wm wi  wt        wd         inv lt        ri   hit idx data      mul rv tag      data      ptr
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00000, 0,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     0);
    addv(0, 1, 0, 5, 20'h12345, 24'hABCDEF,0, 20'h12345, 5,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     0);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h12345, 5,   1, 5, 24'hABCDEF,0, 1, 20'h12345, 24'hABCDEF,0);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00000, 3,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     0);
    // nine random writes, tags 0x100..0x108
    addv(0, 1, 1, 0, 20'h100,   24'h500,   0, 20'h12345, 0,   1, 5, 24'hABCDEF,0, 0, 20'h0,     24'h0,     0);
    addv(0, 1, 1, 0, 20'h101,   24'h501,   0, 20'h12345, 1,   1, 5, 24'hABCDEF,0, 0, 20'h0,     24'h0,     1);
    addv(0, 1, 1, 0, 20'h102,   24'h502,   0, 20'h12345, 2,   1, 5, 24'hABCDEF,0, 0, 20'h0,     24'h0,     2);
    addv(0, 1, 1, 0, 20'h103,   24'h503,   0, 20'h12345, 3,   1, 5, 24'hABCDEF,0, 0, 20'h0,     24'h0,     3);
    addv(0, 1, 1, 0, 20'h104,   24'h504,   0, 20'h12345, 4,   1, 5, 24'hABCDEF,0, 0, 20'h0,     24'h0,     4);
    addv(0, 1, 1, 0, 20'h105,   24'h505,   0, 20'h12345, 5,   1, 5, 24'hABCDEF,0, 1, 20'h12345, 24'hABCDEF,5);
    addv(0, 1, 1, 0, 20'h106,   24'h506,   0, 20'h12345, 6,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     6);
    addv(0, 1, 1, 0, 20'h107,   24'h507,   0, 20'h12345, 7,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     7);
    addv(0, 1, 1, 0, 20'h108,   24'h508,   0, 20'h12345, 0,   0, 0, 24'h0,     0, 1, 20'h100,   24'h500,   0);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00100, 0,   0, 0, 24'h0,     0, 1, 20'h108,   24'h508,   1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00108, 7,   1, 0, 24'h508,   0, 1, 20'h107,   24'h507,   1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00103, 3,   1, 3, 24'h503,   0, 1, 20'h103,   24'h503,   1);
    // duplicate tag at 2 and 6
    addv(0, 1, 0, 2, 20'h0AAAA, 24'hC0002, 0, 20'h0AAAA, 2,   0, 0, 24'h0,     0, 1, 20'h102,   24'h502,   1);
    addv(0, 1, 0, 6, 20'h0AAAA, 24'hC0006, 0, 20'h0AAAA, 6,   1, 2, 24'hC0002, 0, 1, 20'h106,   24'h506,   1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h0AAAA, 6,   1, 2, 24'hC0002, 1, 1, 20'h0AAAA, 24'hC0006, 1);
    // full array: invalidate together with a random write
    addv(0, 1, 1, 0, 20'h777,   24'h777,   1, 20'h00104, 4,   1, 4, 24'h504,   0, 1, 20'h104,   24'h504,   1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00104, 4,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00777, 1,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h0AAAA, 2,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     1);
    // random write after invalidate lands at the unchanged pointer
    addv(0, 1, 1, 0, 20'h222,   24'h333,   0, 20'h00222, 1,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     1);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00222, 1,   1, 1, 24'h333,   0, 1, 20'h222,   24'h333,   2);
    // reset together with a random write: reset wins
    addv(1, 1, 1, 0, 20'h999,   24'h999,   0, 20'h00222, 1,   1, 1, 24'h333,   0, 1, 20'h222,   24'h333,   2);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00999, 2,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     0);
    addv(0, 0, 0, 0, 20'h0,     24'h0,     0, 20'h00222, 1,   0, 0, 24'h0,     0, 0, 20'h0,     24'h0,     0);

    step(); step();
    rst = 1'b0; b_rst = 1'b0;
    #1;

    // reset state: every index of A reads zeros
    for (int i = 0; i < 8; i++) begin
      rd_index = 3'(i);
      #1;
      chk($sformatf("a_rst_rd_valid[%0d]", i), 32'(rd_valid), 32'd0);
      chk($sformatf("a_rst_rd_tag[%0d]", i),   32'(rd_tag),   32'd0);
      chk($sformatf("a_rst_rd_data[%0d]", i),  32'(rd_data),  32'd0);
    end
    step();

    foreach (vq[n]) begin
      rst = vq[n].rst; wr_en = vq[n].we; wr_mode = vq[n].wm; wr_index = vq[n].wi;
      wr_tag = vq[n].wt; wr_data = vq[n].wd; inv_all = vq[n].inv;
      lk_tag = vq[n].lt; rd_index = vq[n].ri;
      #3;
      chk($sformatf("v%0d lk_hit", n),   32'(lk_hit),   32'(vq[n].e_hit));
      chk($sformatf("v%0d lk_index", n), 32'(lk_index), 32'(vq[n].e_idx));
      chk($sformatf("v%0d lk_data", n),  32'(lk_data),  32'(vq[n].e_data));
      chk($sformatf("v%0d lk_multi", n), 32'(lk_multi), 32'(vq[n].e_multi));
      chk($sformatf("v%0d rd_valid", n), 32'(rd_valid), 32'(vq[n].e_rv));
      chk($sformatf("v%0d rd_tag", n),   32'(rd_tag),   32'(vq[n].e_rt));
      chk($sformatf("v%0d rd_data", n),  32'(rd_data),  32'(vq[n].e_rd));
      chk($sformatf("v%0d rnd_ptr", n),  32'(rnd_ptr),  32'(vq[n].e_ptr));
      step();
    end
    rst = 0; wr_en = 0; inv_all = 0;

    // DEPTH 6: out-of-range indexed write is dropped
    b_wr_en = 1; b_wr_mode = 0; b_wr_index = 3'd7; b_wr_tag = 20'h07777; b_wr_data = 24'h077777;
    step();
    b_wr_en = 0;
    b_lk_tag = 20'h07777; b_rd_index = 3'd7;
    #1;
    chk("b_oor_lk_hit",   32'(b_lk_hit),   32'd0);
    chk("b_oor_rd_valid", 32'(b_rd_valid), 32'd0);
    chk("b_oor_rd_tag",   32'(b_rd_tag),   32'd0);
    chk("b_oor_rd_data",  32'(b_rd_data),  32'd0);
    chk("b_oor_rnd_ptr",  32'(b_rnd_ptr),  32'd0);
    for (int i = 0; i < 6; i++) begin
      b_rd_index = 3'(i);
      #1;
      chk($sformatf("b_oor_valid[%0d]", i), 32'(b_rd_valid), 32'd0);
    end
    step();

    // seven random writes: pointer walks 0..5 then wraps to 0
    for (int k = 0; k < 7; k++) begin
      b_wr_en = 1; b_wr_mode = 1; b_wr_tag = 20'h600 + 20'(k); b_wr_data = 24'h800 + 24'(k);
      #2;
      chk($sformatf("b_ptr_before_wr%0d", k), 32'(b_rnd_ptr), 32'(k % 6));
      step();
    end
    b_wr_en = 0;
    #1;
    chk("b_ptr_final", 32'(b_rnd_ptr), 32'd1);
    b_lk_tag = 20'h600; #1;
    chk("b_lk_600_hit", 32'(b_lk_hit), 32'd0);
    b_lk_tag = 20'h606; #1;
    chk("b_lk_606_hit",  32'(b_lk_hit),   32'd1);
    chk("b_lk_606_idx",  32'(b_lk_index), 32'd0);
    chk("b_lk_606_data", 32'(b_lk_data),  32'h806);
    b_lk_tag = 20'h605; #1;
    chk("b_lk_605_idx",  32'(b_lk_index), 32'd5);
    chk("b_lk_605_data", 32'(b_lk_data),  32'h805);
    b_rd_index = 3'd7; #1;
    chk("b_rd7_valid", 32'(b_rd_valid), 32'd0);
    chk("b_rd7_tag",   32'(b_rd_tag),   32'd0);
    b_rd_index = 3'd1; #1;
    chk("b_rd1_tag",   32'(b_rd_tag),   32'h601);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
